pll_reset_sequencer: RTL and testbench

Reset and lock supervisor on the PLL's free-running reference clock. It drives the PLL's active-high `rst`, watches its asynchronous `locked` output, and retries the PLL when lock does not arrive in time. Once lock has been stable for a set time, it releases one reset per PLL output clock domain in a fixed order. Any later loss of lock re-asserts all domain resets and restarts the PLL.

---
 rtl/pll_reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: holds the PLL in reset, waits for a stable lock with
// timeout-driven retries, then releases the per-domain resets one at a time.
module pll_reset_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT       = 100000,
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned N_DOMAINS          = 6,
    parameter int unsigned STAGE_GAP          = 8,
    parameter int unsigned TIMER_W            = 20
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    output logic                 pll_rst,
    output logic [N_DOMAINS-1:0] sys_rst_n,
    output logic                 ready,
    output logic [7:0]           retry_count,
    output logic [7:0]           loss_count
);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(STAGE_GAP - 1);
    localparam logic [N_DOMAINS-1:0] FIRST_BIT  = N_DOMAINS'(1);

    state_t                 state;
    state_t                 state_nx;
    logic [TIMER_W-1:0]     timer;
    logic [TIMER_W-1:0]     timer_nx;
    logic [N_DOMAINS-1:0]   rel_nx;
    logic                   retry_inc;
    logic                   loss_inc;
    logic                   lock_m;
    logic                   lock_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_nx  = state;
        timer_nx  = timer + 1'b1;
        rel_nx    = sys_rst_n;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state)
            PLL_RST: begin
                if (timer == HOLD_LAST) begin
                    state_nx = WAIT_LOCK;
                    timer_nx = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_s) begin
                    state_nx = STABLE;
                    timer_nx = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_inc = 1'b1;
                    state_nx  = PLL_RST;
                    timer_nx  = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    timer_nx = '0;
                end else if (timer == STABLE_LAST) begin
                    rel_nx   = FIRST_BIT;
                    state_nx = (&rel_nx) ? RUN : RELEASE;
                    timer_nx = '0;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    loss_inc = 1'b1;
                    rel_nx   = '0;
                    state_nx = PLL_RST;
                    timer_nx = '0;
                end else if (timer == GAP_LAST) begin
                    // Domains release strictly in order, so shifting in a one
                    // releases the next bit without tracking an index.
                    rel_nx   = (sys_rst_n << 1) | FIRST_BIT;
                    timer_nx = '0;
                    if (&rel_nx) begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    loss_inc = 1'b1;
                    rel_nx   = '0;
                    state_nx = PLL_RST;
                    timer_nx = '0;
                end
            end
            default: begin
                rel_nx   = '0;
                state_nx = PLL_RST;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PLL_RST;
            timer       <= '0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= '0;
            ready       <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            pll_rst   <= (state_nx == PLL_RST);
            sys_rst_n <= rel_nx;
            ready     <= (state == RUN) && lock_s;
            if (retry_inc && (retry_count != 8'hFF)) begin
                retry_count <= retry_count + 8'd1;
            end
            if (loss_inc && (loss_count != 8'hFF)) begin
                loss_count <= loss_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: per-cycle comparison against a phase/age model
// plus directed scenarios with hand-computed timing expectations.
`timescale 1ns/100ps
module tb_pll_reset_sequencer;

    localparam int HOLD = 16;
    localparam int TMO  = 1000;
    localparam int STB  = 256;
    localparam int N    = 6;
    localparam int GAP  = 8;

    localparam int PH_HOLD = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STB  = 2;
    localparam int PH_REL  = 3;
    localparam int PH_RUN  = 4;

    logic         refclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pll_locked = 1'b0;
    logic         pll_rst;
    logic [N-1:0] sys_rst_n;
    logic         ready;
    logic [7:0]   retry_count;
    logic [7:0]   loss_count;

    logic         sat_rst_n = 1'b0;
    logic         sat_locked = 1'b0;
    logic         sat_pll_rst;
    logic [1:0]   sat_sys;
    logic         sat_ready;
    logic [7:0]   sat_retry;
    logic [7:0]   sat_loss;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TMO), .LOCK_STABLE_CYCLES(STB),
        .N_DOMAINS(N), .STAGE_GAP(GAP), .TIMER_W(20)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n), .ready(ready), .retry_count(retry_count),
        .loss_count(loss_count)
    );

    // Tiny timing so the retry counter can reach saturation in a short run.
    pll_reset_sequencer #(
        .RST_HOLD_CYCLES(1), .LOCK_TIMEOUT(2), .LOCK_STABLE_CYCLES(4),
        .N_DOMAINS(2), .STAGE_GAP(1), .TIMER_W(4)
    ) dut_sat (
        .refclk(refclk), .rst_n(sat_rst_n), .pll_locked(sat_locked), .pll_rst(sat_pll_rst),
        .sys_rst_n(sat_sys), .ready(sat_ready), .retry_count(sat_retry),
        .loss_count(sat_loss)
    );

    always #5 refclk = ~refclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase plus cycles-in-phase; released domains follow from elapsed time.
    int           m_phase;
    int           m_age;
    logic         m_s1;
    logic         m_ls;
    logic         m_old;
    logic [N-1:0] m_bits;
    logic         m_ready;
    int           m_retry;
    int           m_loss;

    function automatic logic [N-1:0] released_by(input int age);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            if (k * GAP <= age) m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_lose();
        m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
        m_bits  = '0;
        m_phase = PH_HOLD;
        m_age   = 0;
    endtask

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = PH_HOLD; m_age = 0; m_s1 = 1'b0; m_ls = 1'b0;
            m_bits = '0; m_ready = 1'b0; m_retry = 0; m_loss = 0;
        end else begin
            m_old   = m_ls;
            m_ls    = m_s1;
            m_s1    = pll_locked;
            m_ready = 1'b0;
            case (m_phase)
                PH_HOLD: begin
                    m_age++;
                    if (m_age == HOLD) begin m_phase = PH_WAIT; m_age = 0; end
                end
                PH_WAIT: begin
                    if (m_old) begin
                        m_phase = PH_STB; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == TMO) begin
                            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                            m_phase = PH_HOLD; m_age = 0;
                        end
                    end
                end
                PH_STB: begin
                    if (!m_old) begin
                        m_phase = PH_WAIT; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == STB) begin
                            m_phase = PH_REL; m_age = 0; m_bits = released_by(0);
                        end
                    end
                end
                PH_REL: begin
                    if (!m_old) model_lose();
                    else begin
                        m_age++;
                        m_bits = released_by(m_age);
                        if (m_age == (N - 1) * GAP) begin m_phase = PH_RUN; m_age = 0; end
                    end
                end
                default: begin
                    if (!m_old) model_lose();
                    else m_ready = 1'b1;
                end
            endcase
        end
    end

    always @(negedge refclk) begin
        if (rst_n) begin
            check("pll_rst", {31'd0, pll_rst}, {31'd0, m_phase == PH_HOLD});
            check("sys_rst_n", 32'(sys_rst_n), 32'(m_bits));
            check("ready", {31'd0, ready}, {31'd0, m_ready});
            check("retry_count", 32'(retry_count), 32'(m_retry));
            check("loss_count", 32'(loss_count), 32'(m_loss));
        end
    end

    function automatic bit cond(input int which);
        if (which == 0) return !pll_rst;
        if (which == 1) return pll_rst;
        if (which == 2) return ready;
        return sys_rst_n[which - 10];
    endfunction

    task automatic wait_for(input string name, input int which, input int limit, output int at);
        int n;
        n  = 0;
        at = -1;
        while (!cond(which) && n < limit) begin
            @(negedge refclk);
            n++;
        end
        if (cond(which)) at = cyc;
        else begin
            total++;
            bad++;
            $display("FAIL %s: condition not reached within %0d cycles", name, limit);
        end
    endtask

    task automatic do_reset(output int r0);
        @(negedge refclk);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        r0 = cyc;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, t, t2, c0, c1, d, e, seen;
        int tb[N];

        // Retry saturation on the small instance: one timeout per 3 cycles.
        @(negedge refclk);
        sat_rst_n = 1'b1;
        r0 = cyc;
        for (int k = 1; k <= 300; k++) begin
            while (cyc < r0 + 3 * k) @(negedge refclk);
            if (k <= 3 || k == 254 || k == 255 || k == 256 || k == 300) begin
                check("sat_retry", 32'(sat_retry), (k > 255) ? 32'd255 : 32'(k));
                check("sat_pll_rst", {31'd0, sat_pll_rst}, 32'd1);
            end
        end
        check("sat_loss", 32'(sat_loss), 32'd0);

        // 1: power-on
        rst_n = 1'b0;
        repeat (3) @(negedge refclk);
        check("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
        check("rst_sys", 32'(sys_rst_n), 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        check("rst_loss", 32'(loss_count), 32'd0);
        rst_n = 1'b1;
        r0 = cyc;
        wait_for("s1_pll_rst_fall", 0, 100, t);
        check("s1_hold_len", 32'(t - r0), 32'd16);
        repeat (49) @(negedge refclk);
        pll_locked = 1'b1;
        c0 = cyc;
        wait_for("s1_bit0", 10, 400, tb[0]);
        check("s1_bit0_time", 32'(tb[0] - c0), 32'd259);
        for (int k = 1; k < N; k++) begin
            wait_for("s1_bit", 10 + k, 20, tb[k]);
            check("s1_gap", 32'(tb[k] - tb[k-1]), 32'd8);
        end
        wait_for("s1_ready", 2, 10, t);
        check("s1_ready_time", 32'(t - tb[N-1]), 32'd1);
        check("s1_retry", 32'(retry_count), 32'd0);
        check("s1_loss", 32'(loss_count), 32'd0);

        // 2: stability glitch at STABLE timer=100
        do_reset(r0);
        wait_for("s2_pll_rst_fall", 0, 100, t);
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 103) @(negedge refclk);
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        pll_locked = 1'b1;
        c1 = cyc;
        wait_for("s2_bit0", 10, 400, t);
        check("s2_bit0_time", 32'(t - c1), 32'd259);
        check("s2_retry", 32'(retry_count), 32'd0);

        // 3: timeouts with lock held low
        do_reset(r0);
        wait_for("s3_pll_rst_fall", 0, 100, t);
        check("s3_first_hold", 32'(t - r0), 32'd16);
        for (int i = 1; i <= 3; i++) begin
            wait_for("s3_repulse", 1, 1100, t);
            check("s3_rise_time", 32'(t - r0), 32'(i * 1016));
            check("s3_retry", 32'(retry_count), 32'(i));
            wait_for("s3_refall", 0, 30, t2);
            check("s3_pulse_len", 32'(t2 - t), 32'd16);
        end

        // 4: loss in RUN, then re-lock
        do_reset(r0);
        wait_for("s4_pll_rst_fall", 0, 100, t);
        repeat (5) @(negedge refclk);
        pll_locked = 1'b1;
        wait_for("s4_ready", 2, 600, t);
        repeat (20) @(negedge refclk);
        pll_locked = 1'b0;
        d = cyc;
        repeat (2) @(negedge refclk);
        check("s4_ready_d2", {31'd0, ready}, 32'd1);
        @(negedge refclk);
        check("s4_sys_d3", 32'(sys_rst_n), 32'd0);
        check("s4_ready_d3", {31'd0, ready}, 32'd0);
        check("s4_loss_d3", 32'(loss_count), 32'd1);
        check("s4_pll_rst_d3", {31'd0, pll_rst}, 32'd1);
        pll_locked = 1'b1;
        wait_for("s4_ready_again", 2, 600, t);
        check("s4_ready_again_time", 32'(t - d), 32'd317);
        check("s4_loss_after", 32'(loss_count), 32'd1);

        // 5: loss right after bit 2 rises
        do_reset(r0);
        wait_for("s5_pll_rst_fall", 0, 100, t);
        pll_locked = 1'b1;
        wait_for("s5_bit2", 12, 600, e);
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        check("s5_sys_e2", 32'(sys_rst_n), 32'h7);
        @(negedge refclk);
        check("s5_sys_e3", 32'(sys_rst_n), 32'd0);
        check("s5_loss", 32'(loss_count), 32'd1);
        check("s5_pll_rst", {31'd0, pll_rst}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge refclk);
            if (sys_rst_n[5:3] != 3'b000) seen = 1;
        end
        check("s5_late_bits", 32'(seen), 32'd0);

        // 6: 1 ns async reset pulse in RELEASE, with loss_count still 1
        pll_locked = 1'b1;
        wait_for("s6_bit1", 11, 1200, t);
        check("s6_loss_pre", 32'(loss_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #0.5;
        check("s6_async_pll_rst", {31'd0, pll_rst}, 32'd1);
        check("s6_async_sys", 32'(sys_rst_n), 32'd0);
        check("s6_async_ready", {31'd0, ready}, 32'd0);
        check("s6_async_loss", 32'(loss_count), 32'd0);
        check("s6_async_retry", 32'(retry_count), 32'd0);
        #0.5;
        rst_n = 1'b1;
        c1 = cyc;
        wait_for("s6_pll_rst_fall", 0, 100, t);
        check("s6_hold_len", 32'(t - c1), 32'd16);
        wait_for("s6_ready", 2, 600, t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
